// File: rtl/i2c_byte_engine.sv
// Single-master I2C byte engine: turns START/WRITE/READ/STOP command pulses into
// open-drain SCL/SDA activity with clock stretching and arbitration-loss detection.
module i2c_byte_engine #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             ena,
    input  logic [CNT_W-1:0] clk_cnt,
    input  logic             start,
    input  logic             stop,
    input  logic             read,
    input  logic             write,
    input  logic             ack_in,
    input  logic [7:0]       din,
    output logic             cmd_ack,
    output logic             ack_out,
    output logic             i2c_busy,
    output logic             i2c_al,
    output logic [7:0]       dout,
    input  logic             scl_i,
    output logic             scl_o,
    output logic             scl_oen,
    input  logic             sda_i,
    output logic             sda_o,
    output logic             sda_oen,
    output logic [2:0]       dbg_state_o
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_BIT    = 3'd2,
        ST_ACKBIT = 3'd3,
        ST_STOP   = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       phase_q, phase_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       sr_q, sr_d;
    logic [7:0]       dout_q, dout_d;
    logic             do_write_q, do_write_d;
    logic             do_read_q, do_read_d;
    logic             do_stop_q, do_stop_d;
    logic             ack_in_q, ack_in_d;
    logic             ack_out_q, ack_out_d;
    logic             cmd_ack_q, cmd_ack_d;
    logic             al_q, al_d;
    logic             scl_oen_q, scl_oen_d;
    logic             sda_oen_q, sda_oen_d;
    logic             busy_q, busy_d;
    logic             scl_s1_q, scl_s_q, sda_s1_q, sda_s_q, sda_prev_q;

    logic tick, stretch, active, adv, sample_lost, lost;

    // A released SCL that still reads low at the end of Q1 is a slave stretching the clock.
    always_comb begin
        active      = (state_q == ST_START) || (state_q == ST_BIT) ||
                      (state_q == ST_ACKBIT) || (state_q == ST_STOP);
        tick        = ena && (cnt_q == clk_cnt);
        stretch     = (phase_q == 2'd1) && scl_oen_q && !scl_s_q;
        adv         = active && tick && !stretch;
        sample_lost = sda_oen_q && !sda_s_q;

        cnt_d = cnt_q;
        if (!active) begin
            cnt_d = '0;
        end else if (ena) begin
            if (!tick) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (!stretch) begin
                cnt_d = '0;
            end
        end

        busy_d = busy_q;
        if (scl_s_q && sda_prev_q && !sda_s_q) begin
            busy_d = 1'b1;
        end else if (scl_s_q && !sda_prev_q && sda_s_q) begin
            busy_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        bit_cnt_d  = bit_cnt_q;
        sr_d       = sr_q;
        dout_d     = dout_q;
        do_write_d = do_write_q;
        do_read_d  = do_read_q;
        do_stop_d  = do_stop_q;
        ack_in_d   = ack_in_q;
        ack_out_d  = ack_out_q;
        cmd_ack_d  = 1'b0;
        al_d       = 1'b0;
        lost       = 1'b0;
        scl_oen_d  = scl_oen_q;
        sda_oen_d  = sda_oen_q;

        case (state_q)
            ST_IDLE: begin
                if (start || stop || read || write) begin
                    do_write_d = write;
                    do_read_d  = read && !write;
                    do_stop_d  = stop;
                    ack_in_d   = ack_in;
                    sr_d       = din;
                    phase_d    = 2'd0;
                    bit_cnt_d  = 3'd0;
                    if (start) begin
                        state_d = ST_START;
                    end else if (read || write) begin
                        state_d = ST_BIT;
                    end else begin
                        state_d = ST_STOP;
                    end
                end
            end
            ST_START: begin
                if (adv) begin
                    phase_d = phase_q + 2'd1;
                    if ((phase_q == 2'd1) && sample_lost) begin
                        lost = 1'b1;
                    end
                    if (phase_q == 2'd3) begin
                        if (do_write_q || do_read_q) begin
                            state_d = ST_BIT;
                        end else if (do_stop_q) begin
                            state_d = ST_STOP;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_BIT: begin
                if (adv) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd2) begin
                        if (do_write_q && sample_lost) begin
                            lost = 1'b1;
                        end
                        if (do_read_q) begin
                            sr_d = {sr_q[6:0], sda_s_q};
                        end
                    end
                    if (phase_q == 2'd3) begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (do_write_q) begin
                            sr_d = {sr_q[6:0], 1'b0};
                        end
                        if (bit_cnt_q == 3'd7) begin
                            state_d = ST_ACKBIT;
                            if (do_read_q) begin
                                dout_d = sr_q;
                            end
                        end
                    end
                end
            end
            ST_ACKBIT: begin
                if (adv) begin
                    phase_d = phase_q + 2'd1;
                    if ((phase_q == 2'd2) && do_write_q) begin
                        ack_out_d = sda_s_q;
                    end
                    if (phase_q == 2'd3) begin
                        state_d = do_stop_q ? ST_STOP : ST_DONE;
                    end
                end
            end
            ST_STOP: begin
                if (adv) begin
                    phase_d = phase_q + 2'd1;
                    if (phase_q == 2'd3) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                cmd_ack_d = 1'b1;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (lost) begin
            al_d      = 1'b1;
            cmd_ack_d = 1'b1;
            state_d   = ST_IDLE;
            phase_d   = 2'd0;
        end

        // Pads are registered from the next state; IDLE/DONE keep the last level.
        case (state_d)
            ST_START: begin
                scl_oen_d = (phase_d != 2'd3);
                sda_oen_d = (phase_d == 2'd0) || (phase_d == 2'd1);
            end
            ST_BIT: begin
                scl_oen_d = (phase_d == 2'd1) || (phase_d == 2'd2);
                sda_oen_d = do_write_d ? sr_d[7] : 1'b1;
            end
            ST_ACKBIT: begin
                scl_oen_d = (phase_d == 2'd1) || (phase_d == 2'd2);
                sda_oen_d = do_write_d ? 1'b1 : ack_in_d;
            end
            ST_STOP: begin
                scl_oen_d = (phase_d != 2'd0);
                sda_oen_d = (phase_d == 2'd2) || (phase_d == 2'd3);
            end
            default: begin
            end
        endcase

        if (lost) begin
            scl_oen_d = 1'b1;
            sda_oen_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            phase_q    <= 2'd0;
            bit_cnt_q  <= 3'd0;
            cnt_q      <= '0;
            sr_q       <= 8'h00;
            dout_q     <= 8'h00;
            do_write_q <= 1'b0;
            do_read_q  <= 1'b0;
            do_stop_q  <= 1'b0;
            ack_in_q   <= 1'b0;
            ack_out_q  <= 1'b0;
            cmd_ack_q  <= 1'b0;
            al_q       <= 1'b0;
            scl_oen_q  <= 1'b1;
            sda_oen_q  <= 1'b1;
            busy_q     <= 1'b0;
            scl_s1_q   <= 1'b1;
            scl_s_q    <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s_q    <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            bit_cnt_q  <= bit_cnt_d;
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            dout_q     <= dout_d;
            do_write_q <= do_write_d;
            do_read_q  <= do_read_d;
            do_stop_q  <= do_stop_d;
            ack_in_q   <= ack_in_d;
            ack_out_q  <= ack_out_d;
            cmd_ack_q  <= cmd_ack_d;
            al_q       <= al_d;
            scl_oen_q  <= scl_oen_d;
            sda_oen_q  <= sda_oen_d;
            busy_q     <= busy_d;
            scl_s1_q   <= scl_i;
            scl_s_q    <= scl_s1_q;
            sda_s1_q   <= sda_i;
            sda_s_q    <= sda_s1_q;
            sda_prev_q <= sda_s_q;
        end
    end

    assign cmd_ack     = cmd_ack_q;
    assign ack_out     = ack_out_q;
    assign i2c_busy    = busy_q;
    assign i2c_al      = al_q;
    assign dout        = dout_q;
    assign scl_o       = 1'b0;
    assign sda_o       = 1'b0;
    assign scl_oen     = scl_oen_q;
    assign sda_oen     = sda_oen_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_i2c_byte_engine.sv
// Directed bench for i2c_byte_engine: open-drain bus with a small slave model,
// clk_cnt = 3 so one bit is 16 clk_i cycles.
module tb_i2c_byte_engine;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ena = 1'b1;
  logic [15:0] clk_cnt = 16'd3;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic        ack_in = 1'b0;
  logic [7:0]  din = 8'h00;
  logic        cmd_ack, ack_out, i2c_busy, i2c_al;
  logic [7:0]  dout;
  logic        scl_o, scl_oen, sda_o, sda_oen;
  logic [2:0]  dbg_state_o;

  int n_assert = 0;
  int n_fail = 0;
  int lat;

  // slave side of the bus
  logic       slave_scl = 1'b1;
  logic       slave_sda_force = 1'b1;
  logic       slave_sda_ack, slave_sda_tx;
  int         slave_mode = 0;   // 0 silent, 1 ack a write, 2 transmit tx_byte
  int         ack_at = 9;
  logic [7:0] tx_byte = 8'h00;
  int         rise_cnt = 0;
  int         fall_cnt = 0;
  int         rise_base = 0;
  int         fall_base = 0;
  logic [7:0] obs_byte = 8'h00;
  logic       ninth_sda = 1'b0;
  logic       ninth_oen = 1'b0;

  wire scl_line = (scl_oen ? 1'b1 : scl_o) & slave_scl;
  wire sda_line = (sda_oen ? 1'b1 : sda_o) & slave_sda_ack & slave_sda_tx & slave_sda_force;

  i2c_byte_engine #(.CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ena(ena), .clk_cnt(clk_cnt),
    .start(start), .stop(stop), .read(read), .write(write),
    .ack_in(ack_in), .din(din),
    .cmd_ack(cmd_ack), .ack_out(ack_out), .i2c_busy(i2c_busy), .i2c_al(i2c_al),
    .dout(dout),
    .scl_i(scl_line), .scl_o(scl_o), .scl_oen(scl_oen),
    .sda_i(sda_line), .sda_o(sda_o), .sda_oen(sda_oen),
    .dbg_state_o(dbg_state_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge scl_line) begin
    if ((rise_cnt - rise_base) < 8) obs_byte <= {obs_byte[6:0], sda_line};
    if ((rise_cnt - rise_base) == 8) begin
      ninth_sda <= sda_line;
      ninth_oen <= sda_oen;
    end
    rise_cnt <= rise_cnt + 1;
  end

  always @(negedge scl_line) begin
    fall_cnt <= fall_cnt + 1;
  end

  // slave SDA only changes on SCL falling edges (fall_cnt steps there)
  always_comb begin
    slave_sda_ack = 1'b1;
    slave_sda_tx  = 1'b1;
    if (slave_mode == 1 && (fall_cnt - fall_base) == ack_at) slave_sda_ack = 1'b0;
    if (slave_mode == 2 && (fall_cnt - fall_base) < 8)
      slave_sda_tx = tx_byte[3'(7 - (fall_cnt - fall_base))];
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic s, input logic p, input logic r, input logic w,
                       input logic [7:0] d, input logic ai);
    rise_base = rise_cnt;
    fall_base = fall_cnt;
    start = s; stop = p; read = r; write = w; din = d; ack_in = ai;
    step();
    start = 1'b0; stop = 1'b0; read = 1'b0; write = 1'b0;
  endtask

  // cycles from the accepting edge to the first sample showing cmd_ack
  task automatic wait_ack(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!cmd_ack && n < 2000);
  endtask

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // reset and idle
    rst_i = 1'b1;
    repeat (4) step();
    rst_i = 1'b0;
    step();
    step();
    chk("rst_scl_oen", scl_oen, 1);
    chk("rst_sda_oen", sda_oen, 1);
    chk("rst_cmd_ack", cmd_ack, 0);
    chk("rst_scl_o", scl_o, 0);
    chk("rst_sda_o", sda_o, 0);
    chk("rst_busy", i2c_busy, 0);
    chk("rst_al", i2c_al, 0);
    chk("rst_dout", dout, 8'h00);
    chk("rst_ack_out", ack_out, 0);
    chk("rst_state", dbg_state_o, 0);

    // START + WRITE 0xE8, slave acknowledges
    slave_mode = 1; ack_at = 9;
    issue(1, 0, 0, 1, 8'hE8, 0);
    wait_ack(lat);
    chk("sw_latency", lat, 161);
    chk("sw_bits", obs_byte, 8'hE8);
    chk("sw_ack_out", ack_out, 0);
    chk("sw_busy", i2c_busy, 1);
    chk("sw_al", i2c_al, 0);
    step();
    chk("sw_ack_pulse", cmd_ack, 0);
    chk("sw_scl_held_low", scl_oen, 0);
    chk("sw_sda_released", sda_oen, 1);

    // WRITE 0x12 with read also raised (write wins), nobody acknowledges
    slave_mode = 0;
    issue(0, 0, 1, 1, 8'h12, 0);
    wait_ack(lat);
    chk("w_latency", lat, 145);
    chk("w_bits", obs_byte, 8'h12);
    chk("w_nack", ack_out, 1);

    // READ with NACK, slave sends 0x5A
    slave_mode = 2; tx_byte = 8'h5A;
    issue(0, 0, 1, 0, 8'h00, 1);
    wait_ack(lat);
    chk("r_latency", lat, 145);
    chk("r_dout", dout, 8'h5A);
    chk("r_ninth_sda", ninth_sda, 1);
    chk("r_ninth_oen", ninth_oen, 1);
    chk("r_ack_out_kept", ack_out, 1);

    // STOP alone
    slave_mode = 0;
    issue(0, 1, 0, 0, 8'h00, 0);
    wait_ack(lat);
    chk("p_latency", lat, 17);
    chk("p_busy", i2c_busy, 0);
    chk("p_scl_oen", scl_oen, 1);
    chk("p_sda_oen", sda_oen, 1);
    chk("p_sda_line", sda_line, 1);

    // START + WRITE 0xA5, slave stretches SCL in data bit 3
    slave_mode = 1; ack_at = 9;
    issue(1, 0, 0, 1, 8'hA5, 0);
    fork
      wait_ack(lat);
      begin
        repeat (64) step();
        slave_scl = 1'b0;
        repeat (40) step();
        slave_scl = 1'b1;
      end
    join
    chk("st_latency", lat, 196);
    chk("st_bits", obs_byte, 8'hA5);
    chk("st_ack_out", ack_out, 0);

    // WRITE 0xFF while the bus holds SDA low: arbitration lost
    slave_mode = 0;
    issue(0, 0, 0, 1, 8'hFF, 0);
    slave_sda_force = 1'b0;
    wait_ack(lat);
    chk("al_latency", lat, 12);
    chk("al_pulse", i2c_al, 1);
    chk("al_scl_oen", scl_oen, 1);
    chk("al_sda_oen", sda_oen, 1);
    chk("al_state", dbg_state_o, 0);
    step();
    chk("al_pulse_end", i2c_al, 0);
    chk("al_ack_end", cmd_ack, 0);
    slave_sda_force = 1'b1;
    repeat (4) step();

    // reset in the middle of a transfer releases the lines
    issue(1, 0, 0, 1, 8'h00, 0);
    repeat (30) step();
    chk("mr_scl_low", scl_oen, 0);
    chk("mr_sda_low", sda_oen, 0);
    rst_i = 1'b1;
    step();
    chk("mr_scl_oen", scl_oen, 1);
    chk("mr_sda_oen", sda_oen, 1);
    chk("mr_busy", i2c_busy, 0);
    chk("mr_state", dbg_state_o, 0);
    rst_i = 1'b0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
